// File: rtl/adusb_stream_if.sv
// USB slave-FIFO write port of adusb_stream, grouped for binding monitors.
// master = the streamer (drives the bus), slave = the USB-side FIFO.
interface adusb_stream_if;
  // Handshake: a word is offered while uwr=0 and is captured on the rising
  // edge of uclk; usb_full_n=1 is the ready flag, looked at only between words;
  // upkt=0 over two uclk phases marks the end of a packet.
  logic [15:0] udata;
  logic        uclk;
  logic        uwr;
  logic        ucs;
  logic        upkt;
  logic        usb_full_n;

  modport master (output udata, uclk, uwr, ucs, upkt, input usb_full_n);
  modport slave  (input udata, uclk, uwr, ucs, upkt, output usb_full_n);
endinterface

// File: rtl/adusb_stream.sv
// ADC-to-USB streamer: samples NCH ADC channels every DIV clocks, queues 16-bit
// words in a FIFO and drains them into a USB slave FIFO in PKT_LEN-word packets.
// Optional feature macro ADUSB_TESTPAT_EN replaces ADC data by a 15-bit counter.
module adusb_stream #(
  parameter int DW      = 15,
  parameter int NCH     = 1,
  parameter int PKT_LEN = 256,
  parameter int DIV     = 10,
  parameter int FIFO_AW = 4
) (
  input  logic              clkk,
  input  logic              rstn,
  input  logic              en,
  input  logic              mo,
  input  logic [NCH*DW-1:0] addata,
  output logic              adclk,
  output logic              ovf,
  adusb_stream_if.master    usb,
  output logic [2:0]        dbg_state,
  output logic [15:0]       dbg_wc
);

  localparam int DCW   = $clog2(DIV);
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    PEND_LO = 3'd3,
    PEND_HI = 3'd4
  } state_t;

  state_t state, state_n;

  logic [DCW-1:0] dc;
  logic           tick;
  logic           run;

  logic [15:0]    hold [NCH];
  logic           push_act;
  logic [CHW-1:0] push_idx;
  logic [15:0]    push_word;

  logic [15:0]      mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr;
  logic             empty, full, push_ok, pop;

  logic [15:0] wc, wc_inc;
  logic [15:0] udata_q;
  logic        uwr_c, uclk_c, upkt_c;

  // ---------------- sample timing ----------------
  assign tick  = en && (dc == DCW'(DIV - 1));
  assign adclk = rstn && en && (dc < DCW'(DIV / 2));

  always_ff @(posedge clkk or negedge rstn) begin
    if (!rstn)     dc <= '0;
    else if (!en)  dc <= '0;
    else if (tick) dc <= '0;
    else           dc <= dc + DCW'(1);
  end

  // chip select drops on the first edge out of reset and stays low
  always_ff @(posedge clkk or negedge rstn) begin
    if (!rstn) run <= 1'b0;
    else       run <= 1'b1;
  end
  assign usb.ucs = ~run;

`ifdef ADUSB_TESTPAT_EN
  logic [14:0] tp_cnt;

  always_ff @(posedge clkk or negedge rstn) begin
    if (!rstn)     tp_cnt <= '0;
    else if (tick) tp_cnt <= tp_cnt + 15'd1;
  end
`endif

  // ---------------- holding register and channel sequencer ----------------
  always_ff @(posedge clkk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NCH; k++) hold[k] <= '0;
      push_act <= 1'b0;
      push_idx <= '0;
    end else if (tick) begin
      for (int k = 0; k < NCH; k++) begin
`ifdef ADUSB_TESTPAT_EN
        hold[k] <= {(k == 0) ? mo : 1'b0, tp_cnt};
`else
        hold[k] <= {(k == 0) ? mo : 1'b0, 15'(addata[k*DW +: DW])};
`endif
      end
      push_act <= 1'b1;
      push_idx <= '0;
    end else if (push_act) begin
      if (push_idx == CHW'(NCH - 1)) push_act <= 1'b0;
      else                           push_idx <= push_idx + CHW'(1);
    end
  end

  assign push_word = hold[push_idx];

  // ---------------- word FIFO ----------------
  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign push_ok = push_act && !full;
  assign pop     = (state == STROBE);

  always_ff @(posedge clkk) begin
    if (push_ok) mem[wptr[FIFO_AW-1:0]] <= push_word;
  end

  always_ff @(posedge clkk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push_ok)            wptr <= wptr + 1'b1;
      if (pop)                rptr <= rptr + 1'b1;
      if (push_act && full)   ovf  <= 1'b1;
    end
  end

  // ---------------- drain FSM ----------------
  assign wc_inc = wc + 16'd1;

  always_ff @(posedge clkk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    uwr_c   = 1'b1;
    uclk_c  = 1'b0;
    upkt_c  = 1'b1;
    case (state)
      IDLE: begin
        if (!empty && usb.usb_full_n)
          state_n = SETUP;
        else if (!en && empty && !push_act && (wc != 16'd0))
          state_n = PEND_LO;
      end
      SETUP: begin
        uwr_c   = 1'b0;
        state_n = STROBE;
      end
      STROBE: begin
        uwr_c   = 1'b0;
        uclk_c  = 1'b1;
        state_n = (wc_inc == 16'(PKT_LEN)) ? PEND_LO : IDLE;
      end
      PEND_LO: begin
        upkt_c  = 1'b0;
        state_n = PEND_HI;
      end
      PEND_HI: begin
        upkt_c  = 1'b0;
        uclk_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // the FIFO head is captured on entry to SETUP and held until the next word
  always_ff @(posedge clkk or negedge rstn) begin
    if (!rstn) begin
      udata_q <= '0;
      wc      <= '0;
    end else begin
      if (state == IDLE && state_n == SETUP) udata_q <= mem[rptr[FIFO_AW-1:0]];
      if (state == STROBE)                   wc      <= wc_inc;
      else if (state == PEND_LO)             wc      <= '0;
    end
  end

  assign usb.udata = udata_q;
  assign usb.uwr   = uwr_c;
  assign usb.uclk  = uclk_c;
  assign usb.upkt  = upkt_c;

  assign dbg_state = state;
  assign dbg_wc    = wc;

endmodule
